// File: rtl/fvm_pkg.sv
// Shared definitions for the Flag Vending Machine multiply path.
// This file holds the sequencer state encoding and the operand and product widths.
package fvm_pkg;

    // Width of each multiplier operand (one nibble of the input byte)
    localparam int NIB_W  = 4;

    // Width of the product returned by the parent-level multiplier
    localparam int PROD_W = 8;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ACCUM = 2'd0,   // accepting beats, accumulating the previous product
        DRAIN = 2'd1,   // input closed, last pending product being added
        DONE  = 2'd2    // frame total presented downstream
    } state_t;

endpackage

// File: rtl/mult_accum_seq.sv
// Operand sequencer and product accumulator for the multiply path.
// Each accepted byte is split into two nibbles and registered onto mult_a/mult_b.
// The multiplier lives in the parent, so its product arrives back on mult_s one
// cycle after the beat and is added to the frame accumulator in that cycle.
// This overlaps the accumulation with the next beat, so a frame streams at one
// beat per clock with no bubbles.
// The frame closes on in_last or after FRAME_LEN beats. After one drain cycle
// the total is held on the output handshake until downstream takes it.
module mult_accum_seq
    import fvm_pkg::*;
#(
    parameter int FRAME_LEN = 8,    // beats per frame before automatic close, 1..255
    parameter int ACC_W     = 16    // accumulator width, 8..32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic [NIB_W-1:0]   mult_a,
    output logic [NIB_W-1:0]   mult_b,
    input  logic [PROD_W-1:0]  mult_s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [7:0]         out_count,
    output logic               out_ovf
);

    // Count value held before the beat that fills the frame
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t              state_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [7:0]          count_reg;
    logic                ovf_reg;
    logic                pend_reg;
    logic                out_valid_reg;
    logic [NIB_W-1:0]    mult_a_reg;
    logic [NIB_W-1:0]    mult_b_reg;

    logic                accept;
    logic                close_beat;
    logic [ACC_W:0]      sum_ext;

    // Input readiness depends on state alone, never on in_valid
    assign in_ready   = (state_reg == ACCUM);
    assign accept     = in_valid & in_ready;
    assign close_beat = in_last | (count_reg == LAST_IDX);

    // One extra bit catches the carry out of the accumulator
    assign sum_ext = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, mult_s};

    // Frame sequencer, operand registers and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            pend_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            mult_a_reg    <= '0;
            mult_b_reg    <= '0;
        end else begin
            // Product of the beat accepted last cycle is on mult_s now
            if (pend_reg) begin
                acc_reg <= sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) begin
                    ovf_reg <= 1'b1;
                end
            end
            pend_reg <= 1'b0;

            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        mult_a_reg <= in_data[7:4];
                        mult_b_reg <= in_data[3:0];
                        pend_reg   <= 1'b1;
                        count_reg  <= count_reg + 8'd1;
                        if (close_beat) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The final product is added by the pend path this cycle
                    state_reg     <= DONE;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    // pend is already clear here, so the clears below cannot race an add
                    if (out_ready) begin
                        acc_reg       <= '0;
                        count_reg     <= '0;
                        ovf_reg       <= 1'b0;
                        pend_reg      <= 1'b0;
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCUM;
                    end
                end
                default: begin
                    state_reg     <= ACCUM;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mult_a    = mult_a_reg;
    assign mult_b    = mult_b_reg;
    assign out_valid = out_valid_reg;
    assign out_acc   = acc_reg;
    assign out_count = count_reg;
    assign out_ovf   = ovf_reg;

endmodule
